// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int NREGS_DEF  = 32;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-producer tracking: pending vector, allocation accept and count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS   = NREGS_DEF,
    parameter int ZERO_R0 = 1,
    localparam int AW     = clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             allocEn,
    input  logic [AW-1:0]    allocAddr,
    input  logic [NREGS-1:0] clrMask,
    output logic [NREGS-1:0] pend,
    output logic             allocOk,
    output logic [AW:0]      pendCnt
);

    logic [NREGS-1:0] pendNext;
    logic [AW:0]      cntNext;
    logic             allocR0;

    assign allocR0 = (ZERO_R0 != 0) && (allocAddr == '0);
    assign allocOk = rst_n && allocEn && !pend[allocAddr] && !allocR0;

    // Allocation is applied after the clear so it wins on a shared target.
    always_comb begin
        pendNext = pend & ~clrMask;
        if (allocOk) pendNext[allocAddr] = 1'b1;
        cntNext = '0;
        for (int r = 0; r < NREGS; r++) begin
            cntNext = cntNext + (AW+1)'(pendNext[r]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= '0;
            pendCnt <= '0;
        end else begin
            pend    <= pendNext;
            pendCnt <= cntNext;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port flop register file with write bypass and pending scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int NREGS   = NREGS_DEF,
    parameter int NRD     = 2,
    parameter int NWR     = 2,
    parameter int ZERO_R0 = 1,
    localparam int AW     = clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*AW-1:0]     wr_addr,
    input  logic [NWR*DATA_W-1:0] wr_data,
    input  logic                  alloc_en,
    input  logic [AW-1:0]         alloc_addr,
    output logic                  alloc_ok,
    output logic [AW:0]           pend_cnt
);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NWR-1:0]    wrEff;
    logic [NREGS-1:0]  clrMask;
    logic [NREGS-1:0]  pend;

    always_comb begin
        wrEff   = '0;
        clrMask = '0;
        for (int j = 0; j < NWR; j++) begin
            wrEff[j] = wr_en[j] &&
                !((ZERO_R0 != 0) && (wr_addr[j*AW +: AW] == '0));
            if (wrEff[j]) clrMask[wr_addr[j*AW +: AW]] = 1'b1;
        end
    end

    // Later ports are assigned last, so the higher index wins a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wrEff[j]) begin
                    regs[wr_addr[j*AW +: AW]] <= wr_data[j*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        logic [AW-1:0]     a;
        logic [DATA_W-1:0] v;
        logic              hit;
        rd_data = '0;
        rd_busy = '0;
        a       = '0;
        v       = '0;
        hit     = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            a   = rd_addr[i*AW +: AW];
            v   = regs[a];
            hit = 1'b0;
            for (int j = 0; j < NWR; j++) begin
                if (wrEff[j] && (wr_addr[j*AW +: AW] == a)) begin
                    v   = wr_data[j*DATA_W +: DATA_W];
                    hit = 1'b1;
                end
            end
            if ((ZERO_R0 != 0) && (a == '0)) v = '0;
            if (rst_n) begin
                rd_data[i*DATA_W +: DATA_W] = v;
                rd_busy[i] = pend[a] && !hit;
            end
        end
    end

    regfile_scoreboard #(
        .NREGS  (NREGS),
        .ZERO_R0(ZERO_R0)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .allocEn  (alloc_en),
        .allocAddr(alloc_addr),
        .clrMask  (clrMask),
        .pend     (pend),
        .allocOk  (alloc_ok),
        .pendCnt  (pend_cnt)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed scoreboard bench for regfile_mp with default parameters.
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int AW = 5;

    localparam int K_DATA = 0;
    localparam int K_BUSY = 1;
    localparam int K_OK   = 2;
    localparam int K_CNT  = 3;

    typedef struct {
        string       tag;
        int          kind;
        int          port;
        logic [31:0] val;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [2*AW-1:0] rd_addr;
    logic [2*DW-1:0] rd_data;
    logic [1:0]    rd_busy;
    logic [1:0]    wr_en;
    logic [2*AW-1:0] wr_addr;
    logic [2*DW-1:0] wr_data;
    logic          alloc_en;
    logic [AW-1:0] alloc_addr;
    logic          alloc_ok;
    logic [AW:0]   pend_cnt;

    exp_t expQ[$];
    int   testCnt = 0;
    int   failCnt = 0;

    regfile_mp dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .alloc_en  (alloc_en),
        .alloc_addr(alloc_addr),
        .alloc_ok  (alloc_ok),
        .pend_cnt  (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic idle();
        wr_en      = '0;
        wr_addr    = '0;
        wr_data    = '0;
        alloc_en   = 1'b0;
        alloc_addr = '0;
        rd_addr    = '0;
    endtask

    task automatic setRd(input int p, input int a);
        rd_addr[p*AW +: AW] = AW'(a);
    endtask

    task automatic setWr(input int p, input int a, input logic [31:0] d);
        wr_en[p]            = 1'b1;
        wr_addr[p*AW +: AW] = AW'(a);
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic setAlloc(input int a);
        alloc_en   = 1'b1;
        alloc_addr = AW'(a);
    endtask

    task automatic expect_(input string tag, input int kind,
                           input int port, input logic [31:0] v);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.port = port;
        e.val  = v;
        expQ.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int kind, input int port);
        logic [31:0] o;
        o = '0;
        case (kind)
            K_DATA: o = rd_data[port*DW +: DW];
            K_BUSY: o = {31'b0, rd_busy[port]};
            K_OK:   o = {31'b0, alloc_ok};
            default: o = {26'b0, pend_cnt};
        endcase
        return o;
    endfunction

    task automatic drain();
        exp_t        e;
        logic [31:0] o;
        #1;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            o = observe(e.kind, e.port);
            testCnt++;
            assert (o === e.val) else begin
                failCnt++;
                $error("FAIL %s obs=%h exp=%h", e.tag, o, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        setWr(0, 4, 32'hDEAD);
        setWr(1, 9, 32'hCAFE);
        setAlloc(4);
        setRd(0, 4);
        setRd(1, 9);
        expect_("rst_rd0", K_DATA, 0, 32'h0);
        expect_("rst_rd1", K_DATA, 1, 32'h0);
        expect_("rst_busy0", K_BUSY, 0, 32'h0);
        expect_("rst_ok", K_OK, 0, 32'h0);
        expect_("rst_cnt", K_CNT, 0, 32'h0);
        drain();
        tick();
        tick();
        rst_n = 1'b1;
        idle();

        for (int a = 0; a < 32; a += 2) begin
            setRd(0, a);
            setRd(1, a + 1);
            expect_("init_rd0", K_DATA, 0, 32'h0);
            expect_("init_rd1", K_DATA, 1, 32'h0);
            drain();
            tick();
        end
        expect_("init_cnt", K_CNT, 0, 32'h0);
        drain();

        setWr(0, 5, 32'h1234);
        setWr(1, 5, 32'hBEEF);
        setRd(0, 5);
        setRd(1, 6);
        expect_("coll_byp", K_DATA, 0, 32'hBEEF);
        expect_("coll_other", K_DATA, 1, 32'h0);
        expect_("coll_busy", K_BUSY, 0, 32'h0);
        drain();
        tick();
        idle();
        setRd(0, 5);
        expect_("coll_next", K_DATA, 0, 32'hBEEF);
        drain();

        setWr(0, 6, 32'h1111);
        setRd(1, 6);
        expect_("p0_byp_rd1", K_DATA, 1, 32'h1111);
        drain();
        tick();
        idle();
        setRd(1, 6);
        setRd(0, 5);
        expect_("p0_store", K_DATA, 1, 32'h1111);
        expect_("p0_keep5", K_DATA, 0, 32'hBEEF);
        expect_("p0_busy", K_BUSY, 1, 32'h0);
        expect_("p0_cnt", K_CNT, 0, 32'h0);
        drain();

        setWr(0, 0, 32'hFFFF_FFFF);
        setRd(0, 0);
        expect_("r0_byp", K_DATA, 0, 32'h0);
        drain();
        tick();
        idle();
        setRd(0, 0);
        setAlloc(0);
        expect_("r0_rd", K_DATA, 0, 32'h0);
        expect_("r0_alloc", K_OK, 0, 32'h0);
        drain();
        tick();
        idle();
        expect_("r0_cnt", K_CNT, 0, 32'h0);
        drain();

        setAlloc(7);
        setRd(0, 7);
        expect_("a7_ok", K_OK, 0, 32'h1);
        expect_("a7_busy_pre", K_BUSY, 0, 32'h0);
        drain();
        tick();
        idle();
        setRd(1, 7);
        setAlloc(7);
        expect_("a7_busy", K_BUSY, 1, 32'h1);
        expect_("a7_cnt", K_CNT, 0, 32'h1);
        expect_("a7_again", K_OK, 0, 32'h0);
        drain();
        tick();
        idle();
        setWr(1, 7, 32'h42);
        setRd(0, 7);
        expect_("a7_cnt_hold", K_CNT, 0, 32'h1);
        expect_("w7_busy", K_BUSY, 0, 32'h0);
        expect_("w7_byp", K_DATA, 0, 32'h42);
        drain();
        tick();
        idle();
        setRd(0, 7);
        expect_("w7_cnt", K_CNT, 0, 32'h0);
        expect_("w7_busy_post", K_BUSY, 0, 32'h0);
        expect_("w7_data", K_DATA, 0, 32'h42);
        drain();

        setAlloc(3);
        setWr(0, 3, 32'h9);
        expect_("aw3_ok", K_OK, 0, 32'h1);
        drain();
        tick();
        idle();
        setRd(0, 3);
        setAlloc(3);
        expect_("aw3_data", K_DATA, 0, 32'h9);
        expect_("aw3_busy", K_BUSY, 0, 32'h1);
        expect_("aw3_cnt", K_CNT, 0, 32'h1);
        expect_("aw3_realloc", K_OK, 0, 32'h0);
        drain();
        idle();
        setWr(0, 3, 32'hA);
        tick();
        idle();
        expect_("aw3_clr", K_CNT, 0, 32'h0);
        drain();

        for (int r = 1; r < 32; r++) begin
            setAlloc(r);
            expect_("fill_ok", K_OK, 0, 32'h1);
            drain();
            tick();
        end
        idle();
        setRd(0, 31);
        setRd(1, 1);
        expect_("fill_cnt", K_CNT, 0, 32'd31);
        expect_("fill_busy0", K_BUSY, 0, 32'h1);
        expect_("fill_busy1", K_BUSY, 1, 32'h1);
        drain();

        #2;
        rst_n = 1'b0;
        setWr(0, 7, 32'h5555);
        setWr(1, 8, 32'h6666);
        setAlloc(0);
        setRd(0, 7);
        setRd(1, 5);
        expect_("mid_cnt", K_CNT, 0, 32'h0);
        expect_("mid_rd0", K_DATA, 0, 32'h0);
        expect_("mid_rd1", K_DATA, 1, 32'h0);
        expect_("mid_busy0", K_BUSY, 0, 32'h0);
        expect_("mid_ok", K_OK, 0, 32'h0);
        drain();
        tick();
        idle();
        rst_n = 1'b1;
        for (int a = 0; a < 32; a += 2) begin
            setRd(0, a);
            setRd(1, a + 1);
            expect_("post_rd0", K_DATA, 0, 32'h0);
            expect_("post_rd1", K_DATA, 1, 32'h0);
            expect_("post_busy0", K_BUSY, 0, 32'h0);
            drain();
            tick();
        end
        expect_("post_cnt", K_CNT, 0, 32'h0);
        drain();

        setAlloc(12);
        expect_("post_alloc", K_OK, 0, 32'h1);
        drain();
        tick();
        idle();
        expect_("post_alloc_cnt", K_CNT, 0, 32'h1);
        drain();

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
